xm_mult_pipe: RTL and testbench
===============================

# xm_mult_pipe

Parametrised, pipelined constant-modulus multiplier for the modular-multiplication datapath. It computes r = q × M, where M is one of two compile-time moduli selected per transaction. It is the reduction-side multiply used after the quotient estimate in Barrett/Montgomery steps. Unlike the fixed 80-bit single-modulus multiplier, it has a valid/ready handshake with full backpressure, a configurable depth, a transaction tag, and an optional accumulate input.

## Interface
- QW, 80, quotient width (16..128)
- MW, 176, modulus width (32..256)
- RW, QW+MW, result width (derived; do not override)
- MOD0, XM_P0 from package, modulus for mod_sel=0
- MOD1, XM_P1 from package, modulus for mod_sel=1
- STAGES, 2, pipeline depth / latency in cycles (2..4)
- TAGW, 4, tag width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block accepts input this cycle
- q  in  QW  multiplier operand
- mod_sel  in  1  modulus select
- in_tag  in  TAGW  opaque tag, travels with data
- t  in  RW  addend (only with XM_ACC_EN)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- r  out  RW  result
- r_cout  out  1  carry out of accumulate (only with XM_ACC_EN)
- out_tag  out  TAGW  tag of current result

## Operation
- Transfer on a port occurs when valid && ready are both high in the same cycle.
- Pipeline advance enable: adv = out_ready || !out_valid_int. This is a global stall, so all stages hold together when the output is blocked.
- in_ready = adv, combinational from out_ready and state. in_valid must not depend on in_ready.
- Each stage holds a valid bit. Bubbles propagate as valid=0. Data registers in bubble stages hold don't-care values.
- Stage 1 splits M at bit ML = MW/2 and registers two partial products, pl = q × M[ML-1:0] and ph = q × M[MW-1:ML]. It also registers the tag, and t when XM_ACC_EN is defined.
- Stage 2 computes r = pl + (ph << ML), or pl + (ph << ML) + t under XM_ACC_EN.
- Stages 3..STAGES are pure retiming registers on r, tag, and valid.
- Width rules:
  - The product is exact in RW bits with no truncation.
  - Under XM_ACC_EN the sum is taken modulo 2^RW, and r_cout is bit RW of the full sum.
- Both moduli are constants. Synthesis may optimise zero/one runs in them. Results must equal the exact integer product.
- mod_sel is sampled with q. Consecutive transactions may alternate the modulus freely.

## Timing
- Latency is STAGES cycles from the input transfer to out_valid, assuming no stall. Throughput is 1 per cycle while out_ready=1.
- Each output cycle in which out_ready=0 adds one cycle of delay to every in-flight item. Items are never dropped or reordered.
- While out_valid=1 and out_ready=0:
  - r, out_tag, and r_cout are held stable.
  - in_ready=0.
- Simultaneous output transfer and input transfer in the same cycle is allowed, giving a full-rate stream.
- Reset values: out_valid=0, all stage valid bits 0, r=0, r_cout=0, out_tag=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight items. No output is produced for them. Inputs presented while rst=1 are ignored.

## Configuration
- XM_ACC_EN defined:
  - Ports t and r_cout exist.
  - r = (q × M + t) mod 2^RW and r_cout = carry.
  - t is registered in stage 1.
- XM_ACC_EN undefined:
  - Ports t and r_cout are absent.
  - r = q × M.
  - No adder third operand is generated.

## Structure
- Package xm_pkg holds:
  - XM_P0 and XM_P1 modulus constants, 176-bit field moduli.
  - The default QW/MW localparams.
  - The function xm_mw_split(MW) returning ML.
- One sub-module, xm_pp_stage, computes the two registered partial products with the stall enable. The top module instantiates it once and implements the accumulate, retiming, and handshake logic.

## Test plan
- Single shot: q=1, mod_sel=0, tag=5 → after 2 cycles out_valid=1, r=MOD0, out_tag=5; r=MOD1 for mod_sel=1.
- Max operand: q=2^80−1, mod_sel=0 → r=(2^80−1)×MOD0 exactly. Check against a reference model for 10k random q/mod_sel pairs streamed back-to-back, with every result matching in order.
- Backpressure: send 3 items with out_ready=0 →
  - in_ready drops after the pipe fills.
  - r and out_tag stay stable.
  - Raising out_ready drains all 3 in order with no loss or duplication.
- Random out_ready (50%) with random in_valid → the tag sequence at the output equals the input sequence, and results are correct.
- Reset mid-stream: assert rst for 1 cycle with 2 items in flight →
  - out_valid=0 the next cycle.
  - Neither item is ever output.
  - in_ready=1.
- XM_ACC_EN: q=1, mod_sel=0, t=2^256−MOD0 → r=0, r_cout=1. Then q=0, t=7 → r=7, r_cout=0.

Source files
------------

// File: rtl/xm_pkg.sv
// Shared constants and helpers for the constant-modulus multiplier pipeline.
// Accumulate support is selected elsewhere via the XM_ACC_EN macro.
package xm_pkg;

    localparam int unsigned XM_QW = 80;
    localparam int unsigned XM_MW = 176;

    // Two 176-bit field moduli; long one/zero runs are left for synthesis to exploit
    localparam logic [XM_MW-1:0] XM_P0 = 176'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE_AC73;
    localparam logic [XM_MW-1:0] XM_P1 = 176'hC000_0000_0000_0000_0000_0000_0000_0000_0001_2A5F_0B01;

    function automatic int unsigned xm_mw_split(input int unsigned mw);
        return mw / 2;
    endfunction

endpackage

// File: rtl/xm_pp_stage.sv
// First pipeline stage: registers q times the low and high halves of the selected modulus.
// Used by xm_mult_pipe in both XM_ACC_EN and default builds.
module xm_pp_stage
    import xm_pkg::*;
#(
    parameter int unsigned     QW   = XM_QW,
    parameter int unsigned     MW   = XM_MW,
    parameter int unsigned     ML   = xm_mw_split(MW),
    parameter logic [MW-1:0]   MOD0 = MW'(XM_P0),
    parameter logic [MW-1:0]   MOD1 = MW'(XM_P1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  valid_i,
    input  logic [QW-1:0]         q_i,
    input  logic                  mod_sel_i,
    output logic                  valid_o,
    output logic [QW+ML-1:0]      pl_o,
    output logic [QW+MW-ML-1:0]   ph_o
);

    localparam int unsigned PLW = QW + ML;
    localparam int unsigned PHW = QW + MW - ML;

    logic [MW-1:0]  m_c;
    logic [PLW-1:0] pl_d;
    logic [PHW-1:0] ph_d;
    logic           valid_q;
    logic [PLW-1:0] pl_q;
    logic [PHW-1:0] ph_q;

    assign m_c  = mod_sel_i ? MOD1 : MOD0;
    assign pl_d = PLW'(q_i) * PLW'(m_c[ML-1:0]);
    assign ph_d = PHW'(q_i) * PHW'(m_c[MW-1:ML]);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pl_q    <= '0;
            ph_q    <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            pl_q    <= pl_d;
            ph_q    <= ph_d;
        end
    end

    assign valid_o = valid_q;
    assign pl_o    = pl_q;
    assign ph_o    = ph_q;

endmodule

// File: rtl/xm_mult_pipe.sv
// Pipelined q x M constant-modulus multiplier with valid/ready handshake and tag.
// Define XM_ACC_EN to add the t addend input and r_cout carry output.
module xm_mult_pipe
    import xm_pkg::*;
#(
    parameter int unsigned   QW     = XM_QW,
    parameter int unsigned   MW     = XM_MW,
    parameter int unsigned   RW     = QW + MW,
    parameter logic [MW-1:0] MOD0   = MW'(XM_P0),
    parameter logic [MW-1:0] MOD1   = MW'(XM_P1),
    parameter int unsigned   STAGES = 2,
    parameter int unsigned   TAGW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [QW-1:0]   q,
    input  logic            mod_sel,
    input  logic [TAGW-1:0] in_tag,
`ifdef XM_ACC_EN
    input  logic [RW-1:0]   t,
    output logic            r_cout,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   r,
    output logic [TAGW-1:0] out_tag
);

    localparam int unsigned ML = xm_mw_split(MW);
`ifdef XM_ACC_EN
    localparam int unsigned SW = RW + 1;
`else
    localparam int unsigned SW = RW;
`endif

    logic                 adv_c;
    logic                 s1_valid;
    logic [QW+ML-1:0]     s1_pl;
    logic [QW+MW-ML-1:0]  s1_ph;
    logic [TAGW-1:0]      tag1_q;
    logic [SW-1:0]        sum_d;

    // Per-stage views; index 1 feeds stage 2, index STAGES is the output
    logic                 v_s   [1:STAGES];
    logic [RW-1:0]        r_s   [1:STAGES];
    logic [TAGW-1:0]      tag_s [1:STAGES];
`ifdef XM_ACC_EN
    logic [RW-1:0]        t1_q;
    logic                 c_s   [1:STAGES];
`endif

    // Global stall: every stage moves only when the output slot can be vacated
    assign adv_c    = out_ready || !v_s[STAGES];
    assign in_ready = adv_c;

    xm_pp_stage #(
        .QW   (QW),
        .MW   (MW),
        .ML   (ML),
        .MOD0 (MOD0),
        .MOD1 (MOD1)
    ) u_pp (
        .clk       (clk),
        .rst       (rst),
        .en_i      (adv_c),
        .valid_i   (in_valid),
        .q_i       (q),
        .mod_sel_i (mod_sel),
        .valid_o   (s1_valid),
        .pl_o      (s1_pl),
        .ph_o      (s1_ph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tag1_q <= '0;
`ifdef XM_ACC_EN
            t1_q   <= '0;
`endif
        end else if (adv_c) begin
            tag1_q <= in_tag;
`ifdef XM_ACC_EN
            t1_q   <= t;
`endif
        end
    end

`ifdef XM_ACC_EN
    assign sum_d = SW'(s1_pl) + (SW'(s1_ph) << ML) + SW'(t1_q);
    assign c_s[1] = sum_d[RW];
`else
    assign sum_d = SW'(s1_pl) + (SW'(s1_ph) << ML);
`endif
    assign v_s[1]   = s1_valid;
    assign r_s[1]   = sum_d[RW-1:0];
    assign tag_s[1] = tag1_q;

    // Stage 2 captures the recombined sum; later stages only retime it
    for (genvar k = 2; k <= int'(STAGES); k++) begin : g_stage
        logic            v_q;
        logic [RW-1:0]   r_q;
        logic [TAGW-1:0] tag_q;
`ifdef XM_ACC_EN
        logic            c_q;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                r_q   <= '0;
                tag_q <= '0;
`ifdef XM_ACC_EN
                c_q   <= 1'b0;
`endif
            end else if (adv_c) begin
                v_q   <= v_s[k-1];
                r_q   <= r_s[k-1];
                tag_q <= tag_s[k-1];
`ifdef XM_ACC_EN
                c_q   <= c_s[k-1];
`endif
            end
        end

        assign v_s[k]   = v_q;
        assign r_s[k]   = r_q;
        assign tag_s[k] = tag_q;
`ifdef XM_ACC_EN
        assign c_s[k]   = c_q;
`endif
    end

    assign out_valid = v_s[STAGES];
    assign r         = r_s[STAGES];
    assign out_tag   = tag_s[STAGES];
`ifdef XM_ACC_EN
    assign r_cout    = c_s[STAGES];
`endif

endmodule

// File: tb/tb_xm_mult_pipe.sv
// Self-checking bench for xm_mult_pipe: vector table, handshake corner cases, random streams.
// Also covers the XM_ACC_EN build when that macro is defined.
module tb_xm_mult_pipe;
    import xm_pkg::*;

    localparam int unsigned QW     = 80;
    localparam int unsigned MW     = 176;
    localparam int unsigned RW     = QW + MW;
    localparam int unsigned EW     = RW + 1;
    localparam int unsigned TAGW   = 4;
    localparam int unsigned STAGES = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [QW-1:0]   q;
    logic            mod_sel;
    logic [TAGW-1:0] in_tag;
    logic [RW-1:0]   t_tb;
    logic            out_valid;
    logic            out_ready;
    logic [RW-1:0]   r;
    logic [TAGW-1:0] out_tag;
    logic [RW-1:0]   t_eff;
    logic [EW-1:0]   got_full;

`ifdef XM_ACC_EN
    logic r_cout;
    assign got_full = {r_cout, r};
    assign t_eff    = t_tb;
`else
    assign got_full = {1'b0, r};
    assign t_eff    = '0;
`endif

    always #5 clk = ~clk;

    xm_mult_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .mod_sel   (mod_sel),
        .in_tag    (in_tag),
`ifdef XM_ACC_EN
        .t         (t_tb),
        .r_cout    (r_cout),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .out_tag   (out_tag)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;

    task automatic chk(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Exact integer reference: {carry, r} = q * M + t
    function automatic logic [EW-1:0] model(input logic [QW-1:0] qq, input logic s,
                                            input logic [RW-1:0] tt);
        logic [EW-1:0] m;
        m = s ? EW'(XM_P1) : EW'(XM_P0);
        return EW'(qq) * m + EW'(tt);
    endfunction

    function automatic logic [QW-1:0] rand_q();
        logic [95:0] w;
        w = {$urandom(), $urandom(), $urandom()};
        return QW'(w);
    endfunction

    function automatic logic [RW-1:0] rand_t();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard: accepted inputs queued in order, checked at each output transfer
    typedef struct {
        logic [TAGW-1:0] tag;
        logic [EW-1:0]   res;
    } exp_t;
    exp_t sbq[$];
    exp_t e_pop;
    bit   mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                sbq.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected output", EW'(1), EW'(0));
                    end else begin
                        e_pop = sbq.pop_front();
                        chk("stream r", got_full, e_pop.res);
                        chk("stream tag", EW'(out_tag), EW'(e_pop.tag));
                        n_out++;
                    end
                end
                if (in_valid && in_ready)
                    sbq.push_back('{in_tag, model(q, mod_sel, t_eff)});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one item, holding it until accepted; rnd adds input bubbles and random out_ready
    task automatic send(input logic [QW-1:0] qq, input logic s, input logic [TAGW-1:0] tg,
                        input logic [RW-1:0] tt, input bit rnd);
        bit done;
        int guard;
        done  = 1'b0;
        guard = 0;
        q = qq; mod_sel = s; in_tag = tg; t_tb = tt;
        while (!done) begin
            in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            done = in_valid && in_ready;
            tick();
            guard++;
            if (guard > 1000) begin
                $display("FAIL send timeout: got stuck expected accept");
                $fatal(1);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sbq.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        chk(name, EW'(sbq.size()), EW'(0));
    endtask

    typedef struct {
        logic [QW-1:0]   q;
        logic            sel;
        logic [TAGW-1:0] tag;
        logic [RW-1:0]   t;
        logic [EW-1:0]   exp;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [QW-1:0] qmax;
        logic [QW-1:0] qtop;
        logic [EW-1:0] exp_a;
        int lat;
        int n0;
        int ghost;

        qmax = '1;
        qtop = '0;
        qtop[QW-1] = 1'b1;
        tbl.push_back('{QW'(1), 1'b0, 4'd5,  '0, EW'(XM_P0)});
        tbl.push_back('{QW'(1), 1'b1, 4'd6,  '0, EW'(XM_P1)});
        tbl.push_back('{qmax,   1'b0, 4'd7,  '0, (EW'(XM_P0) << QW) - EW'(XM_P0)});
        tbl.push_back('{QW'(0), 1'b1, 4'd8,  '0, EW'(0)});
        tbl.push_back('{qmax,   1'b1, 4'd9,  '0, (EW'(XM_P1) << QW) - EW'(XM_P1)});
        tbl.push_back('{QW'(2), 1'b0, 4'd10, '0, EW'(XM_P0) << 1});
        tbl.push_back('{qtop,   1'b1, 4'd11, '0, EW'(XM_P1) << (QW - 1)});
`ifdef XM_ACC_EN
        tbl.push_back('{QW'(1), 1'b0, 4'd12, RW'(0) - RW'(XM_P0), {1'b1, RW'(0)}});
        tbl.push_back('{QW'(0), 1'b0, 4'd13, RW'(7), EW'(7)});
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        q = '0; mod_sel = 1'b0; in_tag = '0; t_tb = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset out_valid", EW'(out_valid), EW'(0));
        chk("reset r", got_full, EW'(0));
        chk("reset out_tag", EW'(out_tag), EW'(0));
        chk("reset in_ready", EW'(in_ready), EW'(1));

        // Single-shot vectors with latency measurement
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            q = tbl[i].q; mod_sel = tbl[i].sel; in_tag = tbl[i].tag; t_tb = tbl[i].t;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            chk("table latency", EW'(lat), EW'(STAGES));
            chk("table r", got_full, tbl[i].exp);
            chk("table tag", EW'(out_tag), EW'(tbl[i].tag));
            tick();
        end

        // Backpressure: fill the pipe with out_ready low, then drain in order
        mon_en = 1'b1;
        n0 = n_out;
        out_ready = 1'b0;
        q = rand_q(); mod_sel = 1'b0; in_tag = 4'd1; t_tb = rand_t();
        exp_a = model(q, mod_sel, t_eff);
        in_valid = 1'b1;
        #1 chk("bp in_ready item1", EW'(in_ready), EW'(1));
        tick();
        q = rand_q(); mod_sel = 1'b1; in_tag = 4'd2; t_tb = rand_t();
        #1 chk("bp in_ready item2", EW'(in_ready), EW'(1));
        tick();
        q = rand_q(); mod_sel = 1'b0; in_tag = 4'd3; t_tb = rand_t();
        repeat (3) begin
            #1;
            chk("bp in_ready low", EW'(in_ready), EW'(0));
            chk("bp out_valid", EW'(out_valid), EW'(1));
            chk("bp r held", got_full, exp_a);
            chk("bp tag held", EW'(out_tag), EW'(1));
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        drain("bp drain");
        chk("bp out count", EW'(n_out - n0), EW'(3));

        // Back-to-back random stream at full rate
        for (int i = 0; i < 10000; i++) begin
            logic [QW-1:0] qq;
            qq = (i % 97 == 0) ? qmax : rand_q();
            send(qq, 1'($urandom_range(0, 1)), TAGW'(i), rand_t(), 1'b0);
        end
        drain("stream drain");

        // Random valid and ready
        for (int i = 0; i < 2000; i++)
            send(rand_q(), 1'($urandom_range(0, 1)), TAGW'(i), rand_t(), 1'b1);
        drain("random drain");

        // Reset with two items in flight
        out_ready = 1'b0;
        q = rand_q(); mod_sel = 1'b1; in_tag = 4'd9; in_valid = 1'b1;
        tick();
        q = rand_q(); mod_sel = 1'b0; in_tag = 4'd10;
        tick();
        rst = 1'b1;
        q = rand_q(); in_tag = 4'd11;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst out_valid", EW'(out_valid), EW'(0));
        chk("rst in_ready", EW'(in_ready), EW'(1));
        chk("rst r", got_full, EW'(0));
        out_ready = 1'b1;
        ghost = 0;
        repeat (10) begin
            tick();
            if (out_valid) ghost++;
        end
        chk("rst no ghost output", EW'(ghost), EW'(0));
        chk("rst queue empty", EW'(sbq.size()), EW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
